alu_seq: RTL and testbench

Registered, parametrised successor to the combinational 8080 ALU. It holds the architectural flag register internally as an 8080 PSW image. Operands enter through a valid/ready request channel and results leave through a valid/ready response channel. It adds DAA, CMP, flag restore and a two-pass double-width add (DAD) sequenced by an internal FSM. It sits between the register file/operand muxes and the accumulator/PSW write-back path of the CPU datapath.

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_seq_core.sv | 189 ++++++++++++++++++
 rtl/alu_seq.sv | 164 ++++++++++++++++
 tb/tb_alu_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential 8080-style ALU.
// The PSW layout is {S,Z,0,AC,0,P,1,CY}.
package alu_pkg;

  localparam int ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_INC = 5'd0,
    OP_DEC = 5'd1,
    OP_ADD = 5'd2,
    OP_ADC = 5'd3,
    OP_SUB = 5'd4,
    OP_SBB = 5'd5,
    OP_CMP = 5'd6,
    OP_AND = 5'd7,
    OP_XOR = 5'd8,
    OP_OR  = 5'd9,
    OP_RLC = 5'd10,
    OP_RRC = 5'd11,
    OP_RAL = 5'd12,
    OP_RAR = 5'd13,
    OP_CMA = 5'd14,
    OP_CMC = 5'd15,
    OP_STC = 5'd16,
    OP_DAA = 5'd17,
    OP_DAD = 5'd18
  } alu_op_e;

  localparam int PSW_CY = 0;
  localparam int PSW_P  = 2;
  localparam int PSW_AC = 4;
  localparam int PSW_Z  = 6;
  localparam int PSW_S  = 7;

  localparam logic [7:0] PSW_RESET = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DAD_HI = 2'd1,
    ST_RESP   = 2'd2
  } fsm_state_e;

  function automatic logic parity_even8(input logic [7:0] v);
    return ~^v;
  endfunction

  // Force the constant PSW bits so the image always reads {S,Z,0,AC,0,P,1,CY}.
  function automatic logic [7:0] psw_fix(input logic [7:0] v);
    return {v[7:6], 1'b0, v[4], 1'b0, v[2], 1'b1, v[0]};
  endfunction

endpackage

// File: rtl/alu_seq_core.sv
// Combinational ALU datapath: one operation on A/B with the current PSW,
// producing result, carry out and the next PSW. Used for both DAD passes.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_e           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [7:0]        flag_i,
  output logic [DATA_W-1:0] res_o,
  output logic              cy_o,
  output logic [7:0]        flag_o
);

  logic              cy_in_s;
  logic              ac_in_s;
  logic [DATA_W-1:0] add_x_s;
  logic [DATA_W-1:0] add_y_s;
  logic              add_c_s;
  logic [DATA_W:0]   sum_s;
  logic [4:0]        half_s;
  logic              daa_lo_adj_s;
  logic              daa_hi_adj_s;
  logic [4:0]        daa_half_s;
  logic [8:0]        daa_t1_s;
  logic [8:0]        daa_t2_s;
  logic              daa_ac_s;
  logic              daa_cy_s;
  logic [DATA_W-1:0] res_s;
  logic [DATA_W-1:0] szp_src_s;
  logic              cy_s;
  logic              ac_s;
  logic              upd_szp_s;
  logic [7:0]        nf_s;

  assign cy_in_s = flag_i[PSW_CY];
  assign ac_in_s = flag_i[PSW_AC];

  // Shared adder operand selection; subtraction is A + ~B + ~borrow.
  always_comb begin
    add_x_s = a_i;
    add_y_s = b_i;
    add_c_s = 1'b0;
    case (op_i)
      OP_INC: begin
        add_x_s = b_i;
        add_y_s = {DATA_W{1'b0}};
        add_c_s = 1'b1;
      end
      OP_DEC: begin
        add_x_s = b_i;
        add_y_s = {DATA_W{1'b1}};
      end
      OP_ADC:         add_c_s = cy_in_s;
      OP_SUB, OP_CMP: begin
        add_y_s = ~b_i;
        add_c_s = 1'b1;
      end
      OP_SBB: begin
        add_y_s = ~b_i;
        add_c_s = ~cy_in_s;
      end
      OP_DAD:  add_c_s = cy_in_s;
      default: add_c_s = 1'b0;
    endcase
  end

  assign sum_s  = {1'b0, add_x_s} + {1'b0, add_y_s} + {{DATA_W{1'b0}}, add_c_s};
  assign half_s = {1'b0, add_x_s[3:0]} + {1'b0, add_y_s[3:0]} + {4'd0, add_c_s};

  // Decimal adjust on the low byte; the high check sees the low-adjusted value.
  always_comb begin
    daa_lo_adj_s = (a_i[3:0] > 4'd9) | ac_in_s;
    daa_half_s   = {1'b0, a_i[3:0]} + 5'd6;
    daa_ac_s     = daa_lo_adj_s & daa_half_s[4];
    daa_t1_s     = {1'b0, a_i[7:0]} + (daa_lo_adj_s ? 9'h006 : 9'h000);
    daa_hi_adj_s = (daa_t1_s[7:4] > 4'd9) | cy_in_s | daa_t1_s[8];
    daa_t2_s     = {1'b0, daa_t1_s[7:0]} + (daa_hi_adj_s ? 9'h060 : 9'h000);
    daa_cy_s     = cy_in_s | daa_t1_s[8] | daa_t2_s[8];
  end

  // Per-op result and flag selection.
  always_comb begin
    res_s     = a_i;
    szp_src_s = a_i;
    cy_s      = cy_in_s;
    ac_s      = ac_in_s;
    upd_szp_s = 1'b0;
    case (op_i)
      OP_INC, OP_DEC: begin
        res_s     = sum_s[DATA_W-1:0];
        ac_s      = half_s[4];
        upd_szp_s = 1'b1;
      end
      OP_ADD, OP_ADC: begin
        res_s     = sum_s[DATA_W-1:0];
        cy_s      = sum_s[DATA_W];
        ac_s      = half_s[4];
        upd_szp_s = 1'b1;
      end
      OP_SUB, OP_SBB: begin
        res_s     = sum_s[DATA_W-1:0];
        cy_s      = ~sum_s[DATA_W];
        ac_s      = half_s[4];
        upd_szp_s = 1'b1;
      end
      OP_CMP: begin
        szp_src_s = sum_s[DATA_W-1:0];
        cy_s      = ~sum_s[DATA_W];
        ac_s      = half_s[4];
        upd_szp_s = 1'b1;
      end
      OP_AND: begin
        res_s     = a_i & b_i;
        cy_s      = 1'b0;
        ac_s      = a_i[3] | b_i[3];
        upd_szp_s = 1'b1;
      end
      OP_XOR: begin
        res_s     = a_i ^ b_i;
        cy_s      = 1'b0;
        ac_s      = 1'b0;
        upd_szp_s = 1'b1;
      end
      OP_OR: begin
        res_s     = a_i | b_i;
        cy_s      = 1'b0;
        ac_s      = 1'b0;
        upd_szp_s = 1'b1;
      end
      OP_RLC: begin
        res_s = {a_i[DATA_W-2:0], a_i[DATA_W-1]};
        cy_s  = a_i[DATA_W-1];
      end
      OP_RRC: begin
        res_s = {a_i[0], a_i[DATA_W-1:1]};
        cy_s  = a_i[0];
      end
      OP_RAL: begin
        res_s = {a_i[DATA_W-2:0], cy_in_s};
        cy_s  = a_i[DATA_W-1];
      end
      OP_RAR: begin
        res_s = {cy_in_s, a_i[DATA_W-1:1]};
        cy_s  = a_i[0];
      end
      OP_CMA: res_s = ~a_i;
      OP_CMC: cy_s  = ~cy_in_s;
      OP_STC: cy_s  = 1'b1;
      OP_DAA: begin
        res_s[7:0] = daa_t2_s[7:0];
        cy_s       = daa_cy_s;
        ac_s       = daa_ac_s;
        upd_szp_s  = 1'b1;
      end
      OP_DAD: begin
        res_s = sum_s[DATA_W-1:0];
        cy_s  = sum_s[DATA_W];
      end
      default: res_s = a_i;
    endcase
    if (upd_szp_s) begin
      szp_src_s = (op_i == OP_CMP) ? szp_src_s : res_s;
    end else begin
      szp_src_s = res_s;
    end
  end

  // Merge the touched flag bits into the incoming PSW image.
  always_comb begin
    nf_s         = flag_i;
    nf_s[PSW_CY] = cy_s;
    nf_s[PSW_AC] = ac_s;
    if (upd_szp_s) begin
      nf_s[PSW_S] = szp_src_s[DATA_W-1];
      nf_s[PSW_Z] = (szp_src_s == {DATA_W{1'b0}});
      nf_s[PSW_P] = parity_even8(szp_src_s[7:0]);
    end else begin
      nf_s[PSW_S] = flag_i[PSW_S];
    end
  end

  assign res_o  = res_s;
  assign cy_o   = cy_s;
  assign flag_o = psw_fix(nf_s);

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with internal PSW, valid/ready request and response channels,
// and a two-pass DAD sequenced through IDLE -> DAD_HI -> RESP.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_dat_i,
  input  logic [DATA_W-1:0] b_dat_i,
  input  logic [DATA_W-1:0] a_hi_i,
  input  logic [DATA_W-1:0] b_hi_i,
  input  logic              flag_load_i,
  input  logic [7:0]        flag_dat_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_dat_o,
  output logic [DATA_W-1:0] rsp_hi_o,
  output logic [7:0]        flag_o
);

  if (((DATA_W % 4) != 0) || (DATA_W < 8)) begin : g_bad_data_w
    $error("alu_seq: DATA_W must be a multiple of 4 and at least 8");
  end
  if (OP_W != ALU_OP_W) begin : g_bad_op_w
    $error("alu_seq: OP_W must match the alu_pkg opcode width");
  end

  fsm_state_e        state_q, state_d;
  logic [7:0]        flag_q, flag_d;
  logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
  logic [DATA_W-1:0] rsp_hi_q, rsp_hi_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              dad_cy_q, dad_cy_d;
  logic [DATA_W-1:0] a_hi_q, a_hi_d;
  logic [DATA_W-1:0] b_hi_q, b_hi_d;

  alu_op_e           op_s;
  alu_op_e           core_op_s;
  logic [DATA_W-1:0] core_a_s;
  logic [DATA_W-1:0] core_b_s;
  logic [7:0]        core_flag_in_s;
  logic [DATA_W-1:0] core_res_s;
  logic              core_cy_s;
  logic [7:0]        core_flag_s;
  logic              ready_s;
  logic              accept_s;

  assign op_s     = alu_op_e'(op_i);
  assign ready_s  = ~flag_load_i & ((state_q == ST_IDLE) |
                                    ((state_q == ST_RESP) & rsp_ready_i));
  assign accept_s = req_valid_i & ready_s;

  // Core operand mux: DAD_HI replays the latched high words with the low carry.
  always_comb begin
    core_flag_in_s = flag_q;
    if (state_q == ST_DAD_HI) begin
      core_op_s              = OP_DAD;
      core_a_s               = a_hi_q;
      core_b_s               = b_hi_q;
      core_flag_in_s[PSW_CY] = dad_cy_q;
    end else begin
      core_op_s = op_s;
      core_a_s  = a_dat_i;
      core_b_s  = b_dat_i;
      if (op_s == OP_DAD) begin
        core_flag_in_s[PSW_CY] = 1'b0;
      end else begin
        core_flag_in_s = flag_q;
      end
    end
  end

  alu_seq_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .op_i   (core_op_s),
    .a_i    (core_a_s),
    .b_i    (core_b_s),
    .flag_i (core_flag_in_s),
    .res_o  (core_res_s),
    .cy_o   (core_cy_s),
    .flag_o (core_flag_s)
  );

  // Next-state and register-load logic; PSW restore outranks a request.
  always_comb begin
    state_d   = state_q;
    flag_d    = flag_q;
    rsp_dat_d = rsp_dat_q;
    rsp_hi_d  = rsp_hi_q;
    dad_cy_d  = dad_cy_q;
    a_hi_d    = a_hi_q;
    b_hi_d    = b_hi_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if ((state_q == ST_RESP) && rsp_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
        if (flag_load_i) begin
          flag_d = psw_fix(flag_dat_i);
        end else if (accept_s) begin
          rsp_dat_d = core_res_s;
          if (op_s == OP_DAD) begin
            state_d  = ST_DAD_HI;
            dad_cy_d = core_cy_s;
            a_hi_d   = a_hi_i;
            b_hi_d   = b_hi_i;
          end else begin
            state_d  = ST_RESP;
            rsp_hi_d = {DATA_W{1'b0}};
            flag_d   = core_flag_s;
          end
        end else begin
          flag_d = flag_q;
        end
      end
      ST_DAD_HI: begin
        rsp_hi_d = core_res_s;
        flag_d   = core_flag_s;
        state_d  = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      flag_q      <= PSW_RESET;
      rsp_dat_q   <= {DATA_W{1'b0}};
      rsp_hi_q    <= {DATA_W{1'b0}};
      rsp_valid_q <= 1'b0;
      dad_cy_q    <= 1'b0;
      a_hi_q      <= {DATA_W{1'b0}};
      b_hi_q      <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      flag_q      <= flag_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_hi_q    <= rsp_hi_d;
      rsp_valid_q <= rsp_valid_d;
      dad_cy_q    <= dad_cy_d;
      a_hi_q      <= a_hi_d;
      b_hi_q      <= b_hi_d;
    end
  end

  assign req_ready_o = ready_s;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_hi_o    = rsp_hi_q;
  assign flag_o      = flag_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed plus small randomised bench for alu_seq with a response scoreboard.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [4:0] op_i;
  logic [7:0] a_dat_i, b_dat_i, a_hi_i, b_hi_i;
  logic       flag_load_i;
  logic [7:0] flag_dat_i;
  logic       rsp_valid_o;
  logic       rsp_ready_i;
  logic [7:0] rsp_dat_o, rsp_hi_o, flag_o;

  typedef struct {
    logic [7:0] dat;
    logic [7:0] hi;
    logic [7:0] flag;
    int         lat;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] mflag;

  always #5 clk = ~clk;

  alu_seq #(.DATA_W(8), .OP_W(5)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .op_i        (op_i),
    .a_dat_i     (a_dat_i),
    .b_dat_i     (b_dat_i),
    .a_hi_i      (a_hi_i),
    .b_hi_i      (b_hi_i),
    .flag_load_i (flag_load_i),
    .flag_dat_i  (flag_dat_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_hi_o    (rsp_hi_o),
    .flag_o      (flag_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Independent 8080 reference for the arithmetic/logic subset.
  function automatic logic [15:0] model(input alu_op_e op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] f);
    int ai, bi, ci;
    logic [7:0] r;
    logic c, h;
    ai = int'(a); bi = int'(b); ci = int'(f[0]);
    c = f[0]; h = f[4]; r = a;
    case (op)
      OP_ADD: begin r = 8'(ai + bi); c = (ai + bi) > 255; h = ((ai & 15) + (bi & 15)) > 15; end
      OP_ADC: begin r = 8'(ai + bi + ci); c = (ai + bi + ci) > 255; h = ((ai & 15) + (bi & 15) + ci) > 15; end
      OP_SUB: begin r = 8'(ai - bi); c = ai < bi; h = (ai & 15) >= (bi & 15); end
      OP_SBB: begin r = 8'(ai - bi - ci); c = ai < (bi + ci); h = (ai & 15) >= ((bi & 15) + ci); end
      OP_AND: begin r = a & b; c = 1'b0; h = a[3] | b[3]; end
      OP_OR:  begin r = a | b; c = 1'b0; h = 1'b0; end
      OP_XOR: begin r = a ^ b; c = 1'b0; h = 1'b0; end
      OP_INC: begin r = 8'(bi + 1); h = (bi & 15) == 15; end
      OP_DEC: begin r = 8'(bi - 1); h = (bi & 15) != 0; end
      default: r = a;
    endcase
    return {r, r[7], (r == 8'h00), 1'b0, h, 1'b0, ~^r, 1'b1, c};
  endfunction

  // Called at a negedge; accepts on the next rising edge and records the expectation.
  task automatic issue(input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ahi, input logic [7:0] bhi,
                       input logic [7:0] edat, input logic [7:0] ehi,
                       input logic [7:0] eflag, input int elat, input string tag);
    exp_t e;
    op_i = op; a_dat_i = a; b_dat_i = b; a_hi_i = ahi; b_hi_i = bhi;
    req_valid_i = 1'b1;
    #1;
    chk({tag, "_req_ready"}, req_ready_o, 1);
    e.dat = edat; e.hi = ehi; e.flag = eflag; e.lat = elat; e.tag = tag;
    sb.push_back(e);
    mflag = eflag;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic collect(input int hold);
    int   lat;
    exp_t e;
    lat = 1;
    @(negedge clk);
    while ((rsp_valid_o !== 1'b1) && (lat < 8)) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk({e.tag, "_latency"}, lat, e.lat);
    chk({e.tag, "_dat"}, rsp_dat_o, e.dat);
    chk({e.tag, "_hi"}, rsp_hi_o, e.hi);
    chk({e.tag, "_flag"}, flag_o, e.flag);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({e.tag, "_hold_valid"}, rsp_valid_o, 1);
      chk({e.tag, "_hold_dat"}, rsp_dat_o, e.dat);
      chk({e.tag, "_hold_req_ready"}, req_ready_o, 0);
    end
  endtask

  task automatic drain();
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 rsp_ready_i = 1'b0;
    @(negedge clk);
    chk("drain_valid", rsp_valid_o, 0);
  endtask

  task automatic load_flags(input logic [7:0] v, input logic [7:0] exp, input string tag);
    flag_load_i = 1'b1; flag_dat_i = v;
    @(posedge clk);
    #1 flag_load_i = 1'b0;
    @(negedge clk);
    chk(tag, flag_o, exp);
    mflag = exp;
  endtask

  task automatic run_model(input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                           input string tag);
    logic [15:0] m;
    m = model(op, a, b, mflag);
    issue(op, a, b, 8'h00, 8'h00, m[15:8], 8'h00, m[7:0], 1, tag);
    collect(0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_op_e rops [9] = '{OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_AND, OP_OR, OP_XOR, OP_INC, OP_DEC};
    rst_i = 1'b1; req_valid_i = 1'b0; op_i = 5'd0;
    a_dat_i = 8'h00; b_dat_i = 8'h00; a_hi_i = 8'h00; b_hi_i = 8'h00;
    flag_load_i = 1'b0; flag_dat_i = 8'h00; rsp_ready_i = 1'b0;
    mflag = 8'h02;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("reset_valid", rsp_valid_o, 0);
    chk("reset_dat", rsp_dat_o, 8'h00);
    chk("reset_hi", rsp_hi_o, 8'h00);
    chk("reset_flag", flag_o, 8'h02);
    chk("reset_req_ready", req_ready_o, 1);

    issue(OP_ADD, 8'h3A, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h57, 1, "add");
    collect(0); drain();
    issue(OP_ADC, 8'h01, 8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h06, 1, "adc_carry_in");
    collect(0); drain();
    issue(OP_SUB, 8'h10, 8'h20, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h97, 1, "sub");
    collect(0); drain();
    issue(OP_SBB, 8'h05, 8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h16, 1, "sbb_borrow");
    collect(0); drain();
    issue(OP_CMP, 8'h20, 8'h20, 8'h00, 8'h00, 8'h20, 8'h00, 8'h56, 1, "cmp_equal");
    collect(0); drain();
    issue(OP_STC, 8'h11, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'h57, 1, "stc");
    collect(0); drain();
    issue(OP_RAL, 8'h80, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h57, 1, "ral");
    collect(0); drain();
    issue(OP_RRC, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h57, 1, "rrc");
    collect(0); drain();
    issue(OP_CMA, 8'h0F, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h57, 1, "cma");
    collect(0); drain();
    issue(alu_op_e'(5'd25), 8'h5A, 8'h33, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h57, 1, "undef_op");
    collect(0); drain();

    load_flags(8'h00, 8'h02, "flag_load_zero");
    issue(OP_DAA, 8'h9B, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h13, 1, "daa");
    collect(0); drain();

    load_flags(8'h01, 8'h03, "flag_load_cy");
    issue(OP_DAD, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h02, 2, "dad_no_cy_in");
    collect(0); drain();
    load_flags(8'hC4, 8'hC6, "flag_load_c4");
    issue(OP_DAD, 8'h34, 8'hF0, 8'h12, 8'hF0, 8'h24, 8'h03, 8'hC7, 2, "dad");
    collect(0); drain();

    issue(OP_AND, 8'hF3, 8'h0F, 8'h00, 8'h00, 8'h03, 8'h00, 8'h16, 1, "and_stall");
    collect(3);
    rsp_ready_i = 1'b1;
    issue(OP_XOR, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h86, 1, "xor_b2b");
    rsp_ready_i = 1'b0;
    collect(0); drain();

    op_i = OP_DAD; a_dat_i = 8'hFF; b_dat_i = 8'h01; a_hi_i = 8'h01; b_hi_i = 8'h01;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("rst_dad_valid", rsp_valid_o, 0);
    chk("rst_dad_flag", flag_o, 8'h02);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dad_valid_after", rsp_valid_o, 0);
    chk("rst_dad_flag_after", flag_o, 8'h02);
    mflag = 8'h02;

    flag_load_i = 1'b1; flag_dat_i = 8'hFF;
    op_i = OP_ADD; a_dat_i = 8'h01; b_dat_i = 8'h01; req_valid_i = 1'b1;
    #1;
    chk("fload_req_ready", req_ready_o, 0);
    @(posedge clk);
    #1 flag_load_i = 1'b0; req_valid_i = 1'b0;
    @(negedge clk);
    chk("fload_flag", flag_o, 8'hD7);
    chk("fload_no_rsp", rsp_valid_o, 0);
    mflag = 8'hD7;

    for (int i = 0; i < 20; i++) begin
      run_model(rops[$urandom_range(0, 8)], 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
